// File: rtl/icache_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_buffer
// Brief    : Two-entry instruction line buffer with LLC refill and optional
//            next-line prefetch.
// Revision : 1.0
// ============================================================================
module icache_line_buffer #(
   parameter int ADDR_WIDTH  = 64,
   parameter int LINE_BITS   = 512,
   parameter bit PREFETCH_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  out_misaligned,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] S1_R_ADDR,
   output logic                  S1_R_ADDR_VALID,
   input  logic [LINE_BITS-1:0]  S1_R_DATA,
   input  logic                  S1_R_DATA_VALID
);
   localparam int TAG_W = ADDR_WIDTH - 6;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FILL     = 2'd1,
      ST_PREFETCH = 2'd2,
      ST_DROP     = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_valid;
   logic [TAG_W-1:0]      r_tag  [2];
   logic [LINE_BITS-1:0]  r_data [2];
   logic                  r_ptr;
   logic [ADDR_WIDTH-1:0] r_req_addr;
   logic                  r_req_valid;
   logic [ADDR_WIDTH-1:0] r_pend_pc;
   logic                  r_out_valid;
   logic [31:0]           r_out_inst;
   logic [ADDR_WIDTH-1:0] r_out_pc;
   logic                  r_out_mis;

   logic [1:0]            w_hit_way, w_pf_way;
   logic                  w_hit, w_pf_resident, w_victim, w_misaligned;
   logic                  w_accept, w_accept_miss, w_data_in;
   logic                  w_fill, w_fill_resp, w_req_done, w_pf_issue;
   logic [TAG_W-1:0]      w_pf_tag;
   logic [LINE_BITS-1:0]  w_hit_line;
   logic [8:0]            w_in_sel, w_pend_sel;

   assign w_pf_tag = r_req_addr[ADDR_WIDTH-1:6] + TAG_W'(1);
   assign w_victim = !r_valid[0] ? 1'b0 : (!r_valid[1] ? 1'b1 : r_ptr);

   // The prefetch check ignores the entry about to be overwritten by the fill.
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      assign w_hit_way[gi] = r_valid[gi] && (r_tag[gi] == in_pc[ADDR_WIDTH-1:6]);
      assign w_pf_way[gi]  = r_valid[gi] && (r_tag[gi] == w_pf_tag) && (w_victim != 1'(gi));
   end

   assign w_hit         = |w_hit_way;
   assign w_pf_resident = |w_pf_way;
   assign w_hit_line    = w_hit_way[1] ? r_data[1] : r_data[0];
   assign w_misaligned  = (in_pc[1:0] != 2'b00);
   assign in_ready      = reset && (r_state == ST_IDLE) && !r_out_valid && !flush;
   assign w_accept      = in_valid && in_ready;
   assign w_accept_miss = w_accept && !w_misaligned && !w_hit;
   assign w_data_in     = S1_R_DATA_VALID && r_req_valid;
   assign w_in_sel      = {in_pc[5:2], 5'b0};
   assign w_pend_sel    = {r_pend_pc[5:2], 5'b0};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fill      = 1'b0;
      w_fill_resp = 1'b0;
      w_req_done  = 1'b0;
      w_pf_issue  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept_miss) w_state_nxt = ST_FILL;
         end
         ST_FILL: begin
            if (w_data_in) begin
               w_req_done = 1'b1;
               if (flush) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_fill      = 1'b1;
                  w_fill_resp = 1'b1;
                  w_state_nxt = (PREFETCH_EN && !w_pf_resident) ? ST_PREFETCH : ST_IDLE;
               end
            end else if (flush) begin
               w_state_nxt = ST_DROP;
            end
         end
         ST_PREFETCH: begin
            // First cycle here is the mandatory request gap; nothing is outstanding yet.
            if (!r_req_valid) begin
               if (flush) w_state_nxt = ST_IDLE;
               else       w_pf_issue  = 1'b1;
            end else if (w_data_in) begin
               w_req_done  = 1'b1;
               w_fill      = !flush;
               w_state_nxt = ST_IDLE;
            end else if (flush) begin
               w_state_nxt = ST_DROP;
            end
         end
         ST_DROP: begin
            if (w_data_in) begin
               w_req_done  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_victim]  <= r_req_addr[ADDR_WIDTH-1:6];
         r_data[w_victim] <= S1_R_DATA;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid     <= 2'b00;
         r_ptr       <= 1'b0;
         r_req_addr  <= '0;
         r_req_valid <= 1'b0;
         r_pend_pc   <= '0;
         r_out_valid <= 1'b0;
         r_out_inst  <= 32'h0;
         r_out_pc    <= '0;
         r_out_mis   <= 1'b0;
      end else begin
         if (flush) begin
            r_valid <= 2'b00;
         end else if (w_fill) begin
            r_valid[w_victim] <= 1'b1;
            r_ptr             <= ~r_ptr;
         end

         if (w_accept_miss) begin
            r_req_addr  <= {in_pc[ADDR_WIDTH-1:6], 6'b0};
            r_pend_pc   <= in_pc;
            r_req_valid <= 1'b1;
         end else if (w_pf_issue) begin
            r_req_valid <= 1'b1;
         end else if (w_req_done) begin
            r_req_valid <= 1'b0;
         end
         if ((r_state == ST_FILL) && (w_state_nxt == ST_PREFETCH))
            r_req_addr <= {w_pf_tag, 6'b0};

         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_accept && (w_misaligned || w_hit)) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= in_pc;
            r_out_mis   <= w_misaligned;
            r_out_inst  <= w_misaligned ? 32'h0 : w_hit_line[w_in_sel +: 32];
         end else if (w_fill_resp) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pend_pc;
            r_out_mis   <= 1'b0;
            r_out_inst  <= S1_R_DATA[w_pend_sel +: 32];
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid       = r_out_valid;
   assign out_inst        = r_out_inst;
   assign out_pc          = r_out_pc;
   assign out_misaligned  = r_out_mis;
   assign S1_R_ADDR       = r_req_addr;
   assign S1_R_ADDR_VALID = r_req_valid;

endmodule
`default_nettype wire

// File: tb/tb_icache_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_line_buffer
// Brief    : Directed and random fetch sequences on two line buffers (with and
//            without prefetch) checked against a two-entry cache model.
// Revision : 1.0
// ============================================================================
module tb_icache_line_buffer;
   logic         clk = 1'b0;
   logic         reset, in_valid, out_ready, flush, llc_dv;
   logic [63:0]  in_pc;
   logic [511:0] llc_data;
   bit           sel;
   int           llc_lat, stray_cnt, gap_err, addr_err;
   int           errors = 0, checks = 0;
   logic [63:0]  req_log[$];

   logic        a_in_ready, a_out_valid, a_out_mis, a_addr_valid;
   logic        b_in_ready, b_out_valid, b_out_mis, b_addr_valid;
   logic [31:0] a_out_inst, b_out_inst;
   logic [63:0] a_out_pc, b_out_pc, a_addr, b_addr;
   logic        a_in_valid, b_in_valid, a_dv, b_dv;

   assign a_in_valid = in_valid && !sel;
   assign b_in_valid = in_valid && sel;
   assign a_dv       = llc_dv && !sel;
   assign b_dv       = llc_dv && sel;

   wire        dv_in_ready   = sel ? b_in_ready   : a_in_ready;
   wire        dv_out_valid  = sel ? b_out_valid  : a_out_valid;
   wire [31:0] dv_out_inst   = sel ? b_out_inst   : a_out_inst;
   wire [63:0] dv_out_pc     = sel ? b_out_pc     : a_out_pc;
   wire        dv_out_mis    = sel ? b_out_mis    : a_out_mis;
   wire [63:0] dv_addr       = sel ? b_addr       : a_addr;
   wire        dv_addr_valid = sel ? b_addr_valid : a_addr_valid;

   icache_line_buffer #(.ADDR_WIDTH(64), .LINE_BITS(512), .PREFETCH_EN(1'b1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_pc(in_pc), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_inst(a_out_inst), .out_pc(a_out_pc),
      .out_misaligned(a_out_mis), .flush(flush), .S1_R_ADDR(a_addr), .S1_R_ADDR_VALID(a_addr_valid),
      .S1_R_DATA(llc_data), .S1_R_DATA_VALID(a_dv));

   icache_line_buffer #(.ADDR_WIDTH(64), .LINE_BITS(512), .PREFETCH_EN(1'b0)) u_dut_npf (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_pc(in_pc), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_inst(b_out_inst), .out_pc(b_out_pc),
      .out_misaligned(b_out_mis), .flush(flush), .S1_R_ADDR(b_addr), .S1_R_ADDR_VALID(b_addr_valid),
      .S1_R_DATA(llc_data), .S1_R_DATA_VALID(b_dv));

   always #5 clk = ~clk;

   // Memory contents: word at 0x1004 is 0x00500093, everything else scrambled.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] t;
      t = a[31:0] - 32'h1004;
      return (t * 32'h9E3779B1) ^ 32'h00500093;
   endfunction

   function automatic logic [511:0] make_line(input logic [63:0] a);
      logic [511:0] l;
      for (int w = 0; w < 16; w++) l[w*32 +: 32] = mem_word({a[63:6], 6'(w * 4)});
      return l;
   endfunction

   // Cache model: two lines, first-invalid else round-robin victim.
   logic [63:0] m_line [2];
   bit          m_v [2];
   bit          m_ptr;

   function automatic bit m_has(input logic [63:0] l);
      return (m_v[0] && m_line[0] == l) || (m_v[1] && m_line[1] == l);
   endfunction

   task automatic m_fill(input logic [63:0] l);
      int v;
      v = !m_v[0] ? 0 : (!m_v[1] ? 1 : int'(m_ptr));
      m_v[v] = 1'b1;
      m_line[v] = l;
      m_ptr = !m_ptr;
   endtask

   task automatic m_reset();
      m_v[0] = 1'b0; m_v[1] = 1'b0; m_ptr = 1'b0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // LLC responder: logs each request, answers after llc_lat cycles of valid.
   initial begin : llc
      int cnt;
      int stray_seen;
      bit last_pulse;
      logic [63:0] cur;
      cnt = 0; stray_seen = 0; last_pulse = 1'b0; cur = '0;
      llc_dv = 1'b0; llc_data = '0;
      forever begin
         @(negedge clk);
         llc_dv = 1'b0;
         if (reset !== 1'b1) begin
            cnt = 0; last_pulse = 1'b0;
         end else if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            llc_dv = 1'b1; llc_data = make_line(64'h5000);
            last_pulse = 1'b0;
         end else if (dv_addr_valid === 1'b1) begin
            if (cnt == 0) begin
               if (last_pulse) gap_err++;
               req_log.push_back(dv_addr);
               cur = dv_addr;
            end else if (dv_addr !== cur) begin
               addr_err++;
            end
            cnt++;
            last_pulse = 1'b0;
            if (cnt >= llc_lat) begin
               llc_dv = 1'b1; llc_data = make_line(cur);
               cnt = 0; last_pulse = 1'b1;
            end
         end else begin
            last_pulse = 1'b0;
         end
      end
   end

   task automatic wait_ready();
      int c;
      c = 0;
      while (dv_in_ready !== 1'b1 && c < 300) begin @(negedge clk); c++; end
      check("in_ready_wait", dv_in_ready, 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_reset();
      @(negedge clk);
   endtask

   // One fetch through the model; hold = cycles out_ready stays low after out_valid.
   task automatic fetch(input logic [63:0] pc, input int hold);
      logic [63:0] line, pfl;
      logic [31:0] exp_inst, inst0;
      bit exp_mis, exp_hit, exp_pf, stable;
      int n0, cyc, exp_n;
      line     = {pc[63:6], 6'b0};
      pfl      = line + 64'd64;
      exp_mis  = (pc[1:0] != 2'b00);
      exp_hit  = !exp_mis && m_has(line);
      exp_inst = exp_mis ? 32'h0 : mem_word(pc);
      exp_pf   = 1'b0;
      exp_n    = 0;
      if (!exp_mis && !exp_hit) begin
         m_fill(line);
         exp_n = 1;
         if (!sel && !m_has(pfl)) begin
            exp_pf = 1'b1; exp_n = 2; m_fill(pfl);
         end
      end
      wait_ready();
      n0 = req_log.size();
      out_ready = (hold == 0);
      in_valid = 1'b1; in_pc = pc;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (dv_out_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      check("latency", 64'(cyc), (exp_mis || exp_hit) ? 64'd0 : 64'(llc_lat));
      check("out_inst", {32'h0, dv_out_inst}, {32'h0, exp_inst});
      check("out_pc", dv_out_pc, pc);
      check("out_misaligned", {63'h0, dv_out_mis}, {63'h0, exp_mis});
      if (hold > 0) begin
         inst0 = dv_out_inst; stable = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (dv_out_valid !== 1'b1 || dv_out_inst !== inst0 || dv_in_ready !== 1'b0) stable = 1'b0;
         end
         check("backpressure_hold", {63'h0, stable}, 64'd1);
         out_ready = 1'b1;
      end
      @(negedge clk);
      check("consumed", {63'h0, dv_out_valid}, 64'd0);
      wait_ready();
      check("req_count", 64'(req_log.size() - n0), 64'(exp_n));
      if (exp_n >= 1 && req_log.size() > n0) check("req_line", req_log[n0], line);
      if (exp_pf && req_log.size() > n0 + 1) check("req_prefetch", req_log[n0+1], pfl);
   endtask

   initial begin : main
      bit quiet;
      int n0;
      logic [63:0] pc;
      reset = 1'b0; in_valid = 1'b0; in_pc = '0; out_ready = 1'b1; flush = 1'b0;
      sel = 1'b0; llc_lat = 5; stray_cnt = 0; gap_err = 0; addr_err = 0;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_in_ready", {63'h0, dv_in_ready}, 64'd0);
      check("rst_out_valid", {63'h0, dv_out_valid}, 64'd0);
      check("rst_out_inst", {32'h0, dv_out_inst}, 64'd0);
      check("rst_out_pc", dv_out_pc, 64'd0);
      check("rst_out_mis", {63'h0, dv_out_mis}, 64'd0);
      check("rst_addr", dv_addr, 64'd0);
      check("rst_addr_valid", {63'h0, dv_addr_valid}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      fetch(64'h1004, 0);                       // cold miss, prefetch 0x1040
      check("cold_word", {32'h0, mem_word(64'h1004)}, 64'h00500093);
      fetch(64'h1008, 0);                       // hit
      fetch(64'h1044, 0);                       // prefetched line hits
      fetch(64'h1010, 4);                       // backpressure
      fetch(64'h1002, 0);                       // misaligned
      fetch(64'hFFFF_FFFF_FFFF_FFC0, 0);        // wrap: prefetch 0x0
      fetch(64'h0000_0000_0000_0008, 0);

      // Flush while idle invalidates everything.
      wait_ready();
      flush = 1'b1;
      #1 check("flush_in_ready", {63'h0, dv_in_ready}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      m_v[0] = 1'b0; m_v[1] = 1'b0;
      fetch(64'h0000_0000_0000_0008, 0);

      // Flush one cycle after a miss on 0x4000.
      llc_lat = 5;
      wait_ready();
      n0 = req_log.size();
      in_valid = 1'b1; in_pc = 64'h4000;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      m_v[0] = 1'b0; m_v[1] = 1'b0;
      quiet = 1'b1;
      repeat (10) begin @(negedge clk); if (dv_out_valid !== 1'b0) quiet = 1'b0; end
      check("flush_no_resp", {63'h0, quiet}, 64'd1);
      check("flush_req_count", 64'(req_log.size() - n0), 64'd1);
      fetch(64'h4000, 0);

      // Reset in the middle of a fill, then a stray data pulse while idle.
      llc_lat = 8;
      wait_ready();
      in_valid = 1'b1; in_pc = 64'h5000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mid_addr_valid", {63'h0, dv_addr_valid}, 64'd0);
      check("rst_mid_in_ready", {63'h0, dv_in_ready}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_reset();
      stray_cnt++;
      quiet = 1'b1;
      repeat (3) begin @(negedge clk); if (dv_out_valid !== 1'b0) quiet = 1'b0; end
      check("stray_ignored", {63'h0, quiet}, 64'd1);
      llc_lat = 4;
      fetch(64'h5000, 0);

      // Replacement without prefetch.
      sel = 1'b1;
      do_reset();
      llc_lat = 3;
      fetch(64'h1000, 0);
      fetch(64'h2000, 0);
      fetch(64'h3000, 0);
      fetch(64'h2004, 0);
      fetch(64'h1000, 0);

      // Random traffic on both configurations.
      for (int s = 0; s < 2; s++) begin
         sel = (s == 0);
         do_reset();
         for (int i = 0; i < 40; i++) begin
            pc = 64'h8000 + 64'($urandom_range(0, 5)) * 64 + 64'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            llc_lat = $urandom_range(1, 6);
            fetch(pc, $urandom_range(0, 2));
         end
      end

      check("addr_stable", 64'(addr_err), 64'd0);
      check("req_gap", 64'(gap_err), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/icache_line_buffer.md
ICACHE_LINE_BUFFER -- requirements
Module: icache_line_buffer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte address width on core and LLC sides.
REQ-002 SHALL have parameter LINE_BITS, default 512, line width; line = 64 bytes, fixed.
REQ-003 SHALL have parameter PREFETCH_EN, default 1, enables next-line prefetch.
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  core fetch request valid.
REQ-007 SHALL have port in_pc  input  ADDR_WIDTH  byte address of requested instruction.
REQ-008 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-009 SHALL have port out_valid  output  1  fetched instruction valid; held until out_ready.
REQ-010 SHALL have port out_ready  input  1  core consumes response.
REQ-011 SHALL have port out_inst  output  32  instruction word.
REQ-012 SHALL have port out_pc  output  ADDR_WIDTH  pc of out_inst.
REQ-013 SHALL have port out_misaligned  output  1  in_pc[1:0] != 0; out_inst = 0.
REQ-014 SHALL have port flush  input  1  invalidate all lines, drop pending response.
REQ-015 SHALL have port S1_R_ADDR  output  ADDR_WIDTH  line-aligned LLC read address.
REQ-016 SHALL have port S1_R_ADDR_VALID  output  1  LLC read request, held until data returns.
REQ-017 SHALL have port S1_R_DATA  input  LINE_BITS  returned line.
REQ-018 SHALL have port S1_R_DATA_VALID  input  1  one-cycle pulse, S1_R_DATA valid.

Function
REQ-019 SHALL hold 2 entries: valid, tag = addr[63:6], 512-bit data; victim = first invalid entry, else round-robin pointer toggled on every fill.
REQ-020 SHALL use FSM states IDLE, FILL, PREFETCH, DROP.
REQ-021 SHALL assert in_ready only when state==IDLE, !out_valid, !flush.
REQ-022 SHALL, on accepted hit (cycle N), assert out_valid at N+1 with out_inst = line[pc[5:2]*32 +: 32].
REQ-023 SHALL, on accepted misaligned request, respond at N+1 with out_misaligned=1, no LLC access.
REQ-024 SHALL, on accepted miss, enter FILL: S1_R_ADDR = {pc[63:6],6'b0}, S1_R_ADDR_VALID=1 from N+1 until the cycle S1_R_DATA_VALID is seen (inclusive).
REQ-025 SHALL, on S1_R_DATA_VALID at cycle M in FILL, write victim entry at M and assert out_valid at M+1.
REQ-026 SHALL, after FILL with PREFETCH_EN=1 and line+64 not resident, enter PREFETCH requesting line+64 (mod 2^ADDR_WIDTH, wraps to 0); otherwise return to IDLE.
REQ-027 SHALL, in PREFETCH, fill on S1_R_DATA_VALID, produce no response, then return to IDLE.
REQ-028 SHALL keep S1_R_ADDR stable while S1_R_ADDR_VALID=1 and deassert it for at least one cycle between requests.
REQ-029 SHALL, on flush in IDLE, clear all valid bits and out_valid next cycle.
REQ-030 SHALL, on flush in FILL or PREFETCH, enter DROP: keep S1_R_ADDR_VALID until data returns, discard data, no response, then IDLE; flush has priority over in_valid.
REQ-031 SHALL ignore S1_R_DATA_VALID in IDLE.

Reset
REQ-032 SHALL, with reset low, asynchronously force: state IDLE, all valid=0, victim pointer 0, out_valid=0, out_inst=0, out_pc=0, out_misaligned=0, S1_R_ADDR=0, S1_R_ADDR_VALID=0, in_ready=0 while reset low.
REQ-033 SHALL, on reset during FILL/PREFETCH, abandon the request; late S1_R_DATA_VALID then falls under REQ-031.

Verification
REQ-034 SHALL cover cold miss: pc=0x1004, LLC returns line with word1=0x00500093 after 5 cycles -> S1_R_ADDR=0x1000 held 5 cycles, out_inst=0x00500093 out_pc=0x1004 next cycle, then prefetch S1_R_ADDR=0x1040.
REQ-035 SHALL cover hit: after REQ-034, pc=0x1008 -> out_valid next cycle, no S1_R_ADDR_VALID.
REQ-036 SHALL cover replacement: fill 0x1000, 0x2000, 0x3000 with PREFETCH_EN=0 -> 0x3000 evicts 0x1000; pc=0x1000 misses.
REQ-037 SHALL cover flush mid-FILL: flush one cycle after miss on 0x4000 -> no out_valid, line not resident, next 0x4000 misses.
REQ-038 SHALL cover wrap and misalignment: pc=0xFFFF_FFFF_FFFF_FFC0 -> prefetch address 0x0; pc=0x1002 -> out_misaligned=1, no LLC request.
REQ-039 SHALL cover backpressure: out_ready=0 for 4 cycles -> out_valid/out_inst stable, in_ready=0 until consumed.
